// File: rtl/uart_frame_writer.sv
// UART byte stream to pixel RAM write engine: packs 1-3 bytes per pixel, writes
// linear addresses, optionally ping-pongs between two frame buffers.
module uart_frame_writer #(
  parameter int H_PIX     = 480,
  parameter int V_PIX     = 272,
  parameter int PIX_W     = 16,
  parameter int MSB_FIRST = 1,
  parameter int DBL_BUF   = 1,
  parameter int ADDR_W    = 18,
  parameter int TIMEOUT   = 50000
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              frame_restart,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              rd_buf,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int BYTES = PIX_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] FRAME_OFS = ADDR_W'(H_PIX * V_PIX);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(H_PIX * V_PIX - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(TIMEOUT);

  logic [BC_W-1:0]   byte_cnt;
  logic [ADDR_W-1:0] pix_idx;
  logic              wr_buf;
  logic [GAP_W-1:0]  gap_cnt;
  logic [PIX_W-1:0]  pix_sr;
  logic [PIX_W-1:0]  pix_sr_next;

  logic pix_done;
  logic last_pix;
  logic in_frame;
  logic gap_expire;

  generate
    if (PIX_W == 8) begin : g_single
      assign pix_sr_next = rx_data;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign pix_sr_next = {pix_sr[PIX_W-9:0], rx_data};
    end else begin : g_lsb
      assign pix_sr_next = {rx_data, pix_sr[PIX_W-1:8]};
    end
  endgenerate

  always_comb begin
    pix_done   = rx_done && !frame_restart && (byte_cnt == LAST_BYTE);
    last_pix   = (pix_idx == LAST_PIX);
    in_frame   = (byte_cnt != '0) || (pix_idx != '0);
    // gap_cnt is a down-counter loaded on each byte; expiry is the 1->0 step
    gap_expire = !rx_done && !frame_restart && in_frame && (gap_cnt == GAP_W'(1));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_buf      <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      byte_cnt    <= '0;
      pix_idx     <= '0;
      wr_buf      <= (DBL_BUF != 0);
      gap_cnt     <= '0;
      pix_sr      <= '0;
    end else begin
      wr_en       <= pix_done;
      frame_done  <= pix_done && last_pix;
      timeout_err <= gap_expire;

      if (pix_done) begin
        wr_data <= pix_sr_next;
        wr_addr <= pix_idx + (wr_buf ? FRAME_OFS : '0);
      end

      if (rx_done)
        gap_cnt <= GAP_LOAD;
      else if (in_frame && gap_cnt != '0)
        gap_cnt <= gap_cnt - GAP_W'(1);

      if (frame_restart || gap_expire) begin
        byte_cnt <= '0;
        pix_idx  <= '0;
      end else if (rx_done) begin
        pix_sr <= pix_sr_next;
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt <= '0;
          if (last_pix) begin
            pix_idx <= '0;
            if (DBL_BUF != 0) begin
              rd_buf <= wr_buf;
              wr_buf <= ~wr_buf;
            end
          end else begin
            pix_idx <= pix_idx + ADDR_W'(1);
          end
        end else begin
          byte_cnt <= byte_cnt + BC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_writer.sv
// Bench for uart_frame_writer: three parameterisations share one byte stream and
// are compared every cycle against a byte-list reference model.
module tb_uart_frame_writer;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;
  localparam int TO   = 100;
  localparam int AW   = 5;

  localparam int P_BYTES [3] = '{2, 2, 3};
  localparam int P_MSB   [3] = '{1, 0, 1};
  localparam int P_DBL   [3] = '{1, 0, 0};

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       frame_restart = 1'b0;

  always #5 Clk = ~Clk;

  logic          en   [3];
  logic          rdb  [3];
  logic          fd   [3];
  logic          to   [3];
  logic [AW-1:0] addr [3];
  logic [23:0]   dat  [3];
  logic [15:0]   d_a, d_b;
  logic [23:0]   d_c;

  assign dat[0] = {8'h00, d_a};
  assign dat[1] = {8'h00, d_b};
  assign dat[2] = d_c;

  uart_frame_writer #(.H_PIX(H), .V_PIX(V), .PIX_W(16), .MSB_FIRST(1), .DBL_BUF(1),
                      .ADDR_W(AW), .TIMEOUT(TO)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .rx_data(rx_data), .rx_done(rx_done),
    .frame_restart(frame_restart), .wr_en(en[0]), .wr_addr(addr[0]), .wr_data(d_a),
    .rd_buf(rdb[0]), .frame_done(fd[0]), .timeout_err(to[0]));

  uart_frame_writer #(.H_PIX(H), .V_PIX(V), .PIX_W(16), .MSB_FIRST(0), .DBL_BUF(0),
                      .ADDR_W(AW), .TIMEOUT(TO)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .rx_data(rx_data), .rx_done(rx_done),
    .frame_restart(frame_restart), .wr_en(en[1]), .wr_addr(addr[1]), .wr_data(d_b),
    .rd_buf(rdb[1]), .frame_done(fd[1]), .timeout_err(to[1]));

  uart_frame_writer #(.H_PIX(H), .V_PIX(V), .PIX_W(24), .MSB_FIRST(1), .DBL_BUF(0),
                      .ADDR_W(AW), .TIMEOUT(TO)) u_c (
    .Clk(Clk), .Reset_n(Reset_n), .rx_data(rx_data), .rx_done(rx_done),
    .frame_restart(frame_restart), .wr_en(en[2]), .wr_addr(addr[2]), .wr_data(d_c),
    .rd_buf(rdb[2]), .frame_done(fd[2]), .timeout_err(to[2]));

  // reference model state: bytes collected for the current pixel, pixel index, buffers
  logic [7:0]  m_b [3][3];
  int          m_cnt [3];
  int          m_pix [3];
  int          m_wbuf [3];
  int          m_rbuf [3];
  int          m_idle [3];
  logic        exp_en [3];
  logic        exp_fd [3];
  logic        exp_to [3];
  int          exp_addr [3];
  logic [23:0] exp_dat [3];

  int          n_vec = 0;
  int          n_err = 0;
  int          n_to [3];
  int          n_fd [3];
  logic [23:0] last_dat [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]    = 0;
      m_pix[i]    = 0;
      m_wbuf[i]   = P_DBL[i];
      m_rbuf[i]   = 0;
      m_idle[i]   = 0;
      exp_en[i]   = 1'b0;
      exp_fd[i]   = 1'b0;
      exp_to[i]   = 1'b0;
      exp_addr[i] = 0;
      exp_dat[i]  = '0;
      n_to[i]     = 0;
      n_fd[i]     = 0;
      last_dat[i] = '0;
    end
  endtask

  task automatic model_step(input logic [7:0] d, input logic v, input logic rs);
    for (int i = 0; i < 3; i++) begin
      bit busy;
      logic [23:0] pix;
      busy      = (m_cnt[i] != 0) || (m_pix[i] != 0);
      exp_en[i] = 1'b0;
      exp_fd[i] = 1'b0;
      exp_to[i] = 1'b0;
      if (rs) begin
        m_cnt[i] = 0;
        m_pix[i] = 0;
      end else if (v) begin
        m_b[i][m_cnt[i]] = d;
        m_cnt[i]++;
        m_idle[i] = 0;
        if (m_cnt[i] == P_BYTES[i]) begin
          pix = '0;
          for (int k = 0; k < P_BYTES[i]; k++)
            if (P_MSB[i] != 0) pix = (pix << 8) | 24'(m_b[i][k]);
            else               pix = pix | (24'(m_b[i][k]) << (8 * k));
          exp_en[i]   = 1'b1;
          exp_addr[i] = m_pix[i] + m_wbuf[i] * NPIX;
          exp_dat[i]  = pix;
          m_cnt[i]    = 0;
          if (m_pix[i] == NPIX - 1) begin
            m_pix[i]  = 0;
            exp_fd[i] = 1'b1;
            if (P_DBL[i] != 0) begin
              m_rbuf[i] = m_wbuf[i];
              m_wbuf[i] = 1 - m_wbuf[i];
            end
          end else begin
            m_pix[i]++;
          end
        end
      end else if (busy) begin
        m_idle[i]++;
        if (m_idle[i] == TO) begin
          m_cnt[i]  = 0;
          m_pix[i]  = 0;
          exp_to[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_en[%0d]", i), 32'(en[i]), 32'(exp_en[i]));
      check($sformatf("wr_addr[%0d]", i), 32'(addr[i]), 32'(exp_addr[i]));
      check($sformatf("wr_data[%0d]", i), 32'(dat[i]), 32'(exp_dat[i]));
      check($sformatf("frame_done[%0d]", i), 32'(fd[i]), 32'(exp_fd[i]));
      check($sformatf("timeout_err[%0d]", i), 32'(to[i]), 32'(exp_to[i]));
      check($sformatf("rd_buf[%0d]", i), 32'(rdb[i]), 32'(m_rbuf[i]));
      if (en[i] === 1'b1) last_dat[i] = dat[i];
      if (to[i] === 1'b1) n_to[i]++;
      if (fd[i] === 1'b1) n_fd[i]++;
    end
  endtask

  task automatic cyc(input logic [7:0] d, input logic v, input logic rs);
    rx_data       = d;
    rx_done       = v;
    frame_restart = rs;
    @(posedge Clk);
    model_step(d, v, rs);
    #1;
    check_outputs();
    rx_done       = 1'b0;
    frame_restart = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(8'h00, 1'b0, 1'b0);
  endtask

  // asynchronous reset pulse taken between clock edges
  task automatic do_reset();
    Reset_n = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    @(negedge Clk);
    Reset_n = 1'b1;

    do_reset();
    send(8'hF8); idle(1); send(8'h1F);
    check("pack_msb", 32'(last_dat[0]), 32'h0000F81F);
    check("pack_lsb", 32'(last_dat[1]), 32'h00001FF8);

    do_reset();
    for (int k = 0; k < 16; k++) send(8'($urandom));
    check("frame1_done_a", n_fd[0], 1);
    check("frame1_rdbuf_a", 32'(rdb[0]), 1);
    for (int k = 0; k < 16; k++) send(8'($urandom));
    check("frame2_done_a", n_fd[0], 2);
    check("frame2_rdbuf_a", 32'(rdb[0]), 0);
    check("frames_b", n_fd[1], 2);
    check("frames_c", n_fd[2], 1);

    do_reset();
    for (int k = 0; k < 5; k++) send(8'($urandom));
    idle(TO + 5);
    check("timeout_a", n_to[0], 1);
    check("timeout_c", n_to[2], 1);
    check("timeout_rdbuf_a", 32'(rdb[0]), 0);
    send(8'h5A); send(8'hA5);
    check("post_timeout_addr_a", 32'(addr[0]), 32'(NPIX));

    do_reset();
    for (int k = 0; k < 4; k++) send(8'($urandom));
    idle(2);

    do_reset();
    for (int k = 0; k < 6; k++) send(8'($urandom));
    cyc(8'hAA, 1'b1, 1'b1);
    send(8'h11); send(8'h22);
    check("restart_addr_b", 32'(addr[1]), 0);
    check("restart_data_b", 32'(last_dat[1]), 32'h00002211);

    do_reset();
    send(8'h12); send(8'h34); send(8'h56);
    check("pack_24", 32'(last_dat[2]), 32'h00123456);
    send(8'h77); send(8'h88);
    do_reset();
    send(8'h9A); send(8'hBC); send(8'hDE);
    check("after_reset_addr_c", 32'(addr[2]), 0);
    check("after_reset_data_c", 32'(last_dat[2]), 32'h009ABCDE);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 4)       idle(int'($urandom_range(TO - 3, TO + 3)));
      else if (r < 10) cyc(8'($urandom), 1'($urandom), 1'b1);
      else if (r < 11) do_reset();
      else             cyc(8'($urandom), ($urandom_range(0, 9) < 6), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_frame_writer.md
# uart_frame_writer

Parametrised UART-to-frame-buffer write engine for the UART→RAM→TFT display path. It collects bytes from the UART receiver and packs them into pixels of 8, 16 or 24 bits. It drives the write port (port A) of the dual-port pixel RAM with linearly advancing addresses. Optional double buffering hands the TFT read side a stable, completed frame. A byte-gap timeout resynchronises a partial frame.

## Interface
- H_PIX, 480: active pixels per line.
- V_PIX, 272: active lines per frame.
- PIX_W, 16: pixel width in bits; legal values 8, 16, 24; BYTES = PIX_W/8.
- MSB_FIRST, 1: 1 = first received byte lands in the most significant byte of the pixel; 0 = least significant.
- DBL_BUF, 1: 1 = two frame buffers (ping-pong); 0 = single buffer.
- ADDR_W, 18: RAM address width; must satisfy 2^ADDR_W ≥ H_PIX*V_PIX*(DBL_BUF+1).
- TIMEOUT, 50000: maximum byte gap in Clk cycles inside a frame (1 ms at 50 MHz).

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: asynchronous, active-low reset.
- rx_data, input, 8: received byte; valid only while rx_done is high.
- rx_done, input, 1: single-cycle strobe from the UART receiver.
- frame_restart, input, 1: synchronous request to abandon the current frame and restart at pixel 0.
- wr_en, output, 1: RAM port A write enable (ena and wea).
- wr_addr, output, ADDR_W: RAM port A address.
- wr_data, output, PIX_W: RAM port A write data.
- rd_buf, output, 1: buffer index the TFT reader must use, as address offset rd_buf*H_PIX*V_PIX; constant 0 when DBL_BUF=0.
- frame_done, output, 1: single-cycle pulse, a full frame has been written.
- timeout_err, output, 1: single-cycle pulse, a partial frame was discarded because of the byte-gap timeout.

## Operation
State registers:
- byte_cnt, 0..BYTES-1.
- pix_idx, 0..H_PIX*V_PIX-1.
- wr_buf: buffer currently being written.
- gap counter.
- pixel shift register.

Rules:
- Byte collection: each rx_done stores rx_data into the shift register and increments byte_cnt.
  - MSB_FIRST=1: shift left, new byte enters at bits [7:0].
  - MSB_FIRST=0: new byte enters at the top; after BYTES bytes, the first byte sits in bits [7:0].
- Pixel complete: on the rx_done that carries the BYTES-th byte:
  - next cycle: wr_en=1 for exactly one cycle;
  - wr_data = assembled pixel;
  - wr_addr = pix_idx + wr_buf*H_PIX*V_PIX;
  - then pix_idx increments and byte_cnt returns to 0.
- Frame end: when the pixel written has pix_idx = H_PIX*V_PIX-1:
  - pix_idx wraps to 0;
  - frame_done pulses in the same cycle as that final wr_en;
  - if DBL_BUF=1, in that same cycle rd_buf takes the value of wr_buf and wr_buf toggles. The TFT side therefore never sees a buffer that is being written.
- Timeout: the gap counter resets on every rx_done and counts while a frame is in progress (byte_cnt≠0 or pix_idx≠0).
  - When it reaches TIMEOUT: byte_cnt and pix_idx clear to 0, timeout_err pulses for 1 cycle, and wr_buf/rd_buf are unchanged (the partial buffer is overwritten later).
  - The counter saturates and stays idle until the next rx_done.
- frame_restart: same effect as a timeout, but timeout_err is not pulsed.
- Address arithmetic: the offset H_PIX*V_PIX is a compile-time constant, computed at ADDR_W width. Overflow is impossible given the ADDR_W rule.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, rd_buf=0, frame_done=0, timeout_err=0. Internal: byte_cnt=0, pix_idx=0, wr_buf=0 (1 if DBL_BUF=1, so that rd_buf=0 shows the idle buffer), gap counter=0.
- Latency: rx_done of the last byte of a pixel at cycle N → wr_en, wr_addr and wr_data valid at cycle N+1, all registered outputs.
- The block does not back-pressure. rx_done strobes may arrive on consecutive cycles and every one is accepted, including a strobe in the same cycle as wr_en.
- frame_restart and rx_done in the same cycle: restart wins and the byte is dropped. A pending wr_en from cycle N-1 still completes.
- Timeout expiry and rx_done in the same cycle: rx_done wins; no timeout, and the byte is accepted.
- Reset_n asserted mid-frame: all state clears immediately. No partial write is issued after release.

## Test plan
All scenarios use H_PIX=4, V_PIX=2, PIX_W=16, TIMEOUT=100 unless stated.

- Pixel packing, MSB_FIRST=1: bytes 0xF8, 0x1F → one wr_en, wr_addr=0, wr_data=0xF81F. With MSB_FIRST=0, same bytes → wr_data=0x1FF8.
- Frame and ping-pong, DBL_BUF=1: 16 bytes → addresses 8..15 written, frame_done with the 8th wr_en, rd_buf goes 0→1. Next 16 bytes → addresses 0..7, rd_buf goes 1→0.
- Timeout: 5 bytes, then 100 idle cycles → timeout_err pulse, no 3rd write; rd_buf unchanged. Next 2 bytes are written at the start address of the same buffer.
- Back-to-back strobes: rx_done high for 4 consecutive cycles → 2 writes, one cycle apart, with consecutive addresses.
- frame_restart coincident with rx_done after 3 pixels → byte dropped; next 2 bytes are written at buffer offset + 0.
- PIX_W=24, MSB_FIRST=1, DBL_BUF=0: bytes 0x12, 0x34, 0x56 → wr_data=0x123456, wr_addr=0. Async Reset_n pulse mid-pixel → all outputs 0; the next 3 bytes are again written to address 0.
